step_controller: RTL and testbench
==================================

Name: step_controller

Overview:
- Execution-control stage directly downstream of the button debouncers. It consumes their single-cycle press pulses and generates the processor core's clock-enable.
- Supports four modes: halted, single-step, free run, and fixed-length burst.
- Accepts a breakpoint/halt request from the core and counts executed cycles for display on the board.

Parameters:
BURST_LEN, 16, number of enabled cycles per burst; legal range 1..65535
CNT_W, 32, width of the executed-cycle counter

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset_n  input  1  synchronous active-low reset, sampled on rising edge of Clock
step_btn  input  1  one-cycle pulse from debouncer: execute one cycle
run_btn  input  1  one-cycle pulse from debouncer: toggle run/halt
burst_btn  input  1  one-cycle pulse from debouncer: execute BURST_LEN cycles
break_req  input  1  level from core: request halt (ebreak/breakpoint)
count_clr  input  1  one-cycle pulse: clear step_count
cpu_en  output  1  core clock-enable; core advances on cycles where cpu_en=1
halted  output  1  1 when state is HALT
mode  output  2  current state encoding: 0=HALT, 1=STEP, 2=RUN, 3=BURST
step_count  output  CNT_W  number of cycles with cpu_en=1 since reset/clear

Behaviour:
- Reset: synchronous, active-low, applied on any cycle Reset_n=0, including mid-RUN or mid-BURST.
  - Next state HALT, cpu_en=0, halted=1, mode=0, step_count=0, burst counter=0.
  - All button pulses are ignored during reset.
- Output timing:
  - Moore outputs: cpu_en=1 iff state is STEP, RUN or BURST; halted=(state==HALT); mode=state. All outputs are registered (no combinational path from inputs).
  - Latency from a button pulse in cycle t to the first cpu_en=1 is cycle t+1.
- State HALT:
  - Priority on simultaneous pulses: run_btn > burst_btn > step_btn.
  - run_btn goes to RUN.
  - burst_btn goes to BURST and loads remaining=BURST_LEN.
  - step_btn goes to STEP.
  - break_req is ignored in HALT, so the core can be restarted while still asserting it.
- State STEP:
  - Always returns to HALT after exactly one cycle, giving exactly one cpu_en=1 cycle.
  - All inputs are ignored in STEP.
- State RUN:
  - run_btn=1 or break_req=1 goes to HALT. The current cycle still has cpu_en=1; cpu_en drops the next cycle.
  - step_btn and burst_btn are ignored.
- State BURST:
  - remaining decrements on each BURST cycle.
  - When remaining==1, the next state is HALT, giving exactly BURST_LEN cpu_en cycles.
  - run_btn or break_req aborts to HALT the next cycle; remaining is cleared to 0.
  - step_btn and burst_btn are ignored; a burst is not re-triggerable.
- Burst counter: width $clog2(BURST_LEN+1); never underflows. BURST_LEN=1 behaves identically to STEP, apart from mode=3.
- step_count:
  - Increments by 1 in every cycle where cpu_en=1.
  - Wraps modulo 2^CNT_W (all-ones to 0) with no flag.
  - count_clr sets it to 0 on the next edge. If count_clr coincides with an increment, clear wins and the result is 0, not 1.
  - count_clr is honoured in every state.
- Button pulses longer than one cycle are not expected. If a pulse is held, each cycle is evaluated independently under the rules above; e.g. a held run_btn toggles RUN/HALT every cycle.

Test Plan:
- Reset, then step_btn pulse at cycle 5 -> cpu_en=1 only at cycle 6, mode=1 at cycle 6, halted=1 from cycle 7, step_count=1.
- With BURST_LEN=16: burst_btn pulse -> exactly 16 consecutive cpu_en=1 cycles, then HALT; step_count=16. A second burst_btn mid-burst does not extend it (still 16).
- run_btn -> RUN. break_req raised after 100 enabled cycles -> cpu_en low the following cycle, mode=0, step_count=101. run_btn with break_req still high -> RUN resumes.
- In HALT, run_btn, burst_btn and step_btn pulsed in the same cycle -> mode=2 (RUN) next cycle. In RUN, run_btn -> HALT next cycle.
- Reset_n=0 for one cycle mid-BURST (remaining=7) -> next cycle cpu_en=0, mode=0, step_count=0. A subsequent burst runs a full 16 cycles.
- With CNT_W=4: 15 steps then 1 more -> step_count wraps 15 to 0. count_clr coincident with an enabled RUN cycle -> step_count=0.

Source files
------------

// File: rtl/step_controller.sv
// step_controller: turns debounced button pulses into the core clock-enable.
// Four modes (HALT, STEP, RUN, BURST), breakpoint halt from the core, and a
// wrapping counter of enabled cycles for the board display.
module step_controller #(
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             step_btn,
  input  logic             run_btn,
  input  logic             burst_btn,
  input  logic             break_req,
  input  logic             count_clr,
  output logic             cpu_en,
  output logic             halted,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] step_count
);

  // Wide enough to hold BURST_LEN itself.
  localparam int RW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_STEP  = 2'd1,
    S_RUN   = 2'd2,
    S_BURST = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_en_q, cpu_en_d;
  logic             halted_q, halted_d;
  logic [1:0]       mode_q, mode_d;

  // Next-state, burst countdown, cycle counter and registered Moore outputs.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      S_HALT: begin
        // break_req is deliberately ignored so the core can be restarted
        // while it still holds its breakpoint request.
        if (run_btn) begin
          state_d = S_RUN;
        end else if (burst_btn) begin
          state_d = S_BURST;
          rem_d   = RW'(BURST_LEN);
        end else if (step_btn) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        state_d = S_HALT;
      end
      S_RUN: begin
        if (run_btn || break_req) begin
          state_d = S_HALT;
        end
      end
      S_BURST: begin
        // Abort or last cycle both leave the countdown at zero.
        if (run_btn || break_req || (rem_q == RW'(1))) begin
          state_d = S_HALT;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - RW'(1);
        end
      end
      default: begin
        state_d = S_HALT;
        rem_d   = '0;
      end
    endcase

    // Counts cycles in which the core is currently enabled; clear dominates.
    if (count_clr) begin
      cnt_d = '0;
    end else if (cpu_en_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Outputs are decoded from the next state so they appear as flops.
    cpu_en_d = (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
    mode_d   = state_d;
  end

  // State, countdown, counter and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q  <= S_HALT;
      rem_q    <= '0;
      cnt_q    <= '0;
      cpu_en_q <= 1'b0;
      halted_q <= 1'b1;
      mode_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      cpu_en_q <= cpu_en_d;
      halted_q <= halted_d;
      mode_q   <= mode_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign halted     = halted_q;
  assign mode       = mode_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_step_controller.sv
// Scoreboard bench for step_controller: the driver queues the expected
// outputs for each cycle it drives; a monitor pops and compares after the edge.
module tb_step_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: BURST_LEN=16, CNT_W=32
  logic a_rstn = 1'b0, a_st = 1'b0, a_rn = 1'b0, a_bu = 1'b0, a_bk = 1'b0, a_cl = 1'b0;
  logic a_en, a_hl;
  logic [1:0] a_md;
  logic [31:0] a_cnt;

  // Instance B: BURST_LEN=16, CNT_W=4 (wrap check)
  logic b_rstn = 1'b0, b_st = 1'b0, b_rn = 1'b0, b_bu = 1'b0, b_bk = 1'b0, b_cl = 1'b0;
  logic b_en, b_hl;
  logic [1:0] b_md;
  logic [3:0] b_cnt;

  step_controller #(.BURST_LEN(16), .CNT_W(32)) dut_a (
    .Clock(clk), .Reset_n(a_rstn), .step_btn(a_st), .run_btn(a_rn),
    .burst_btn(a_bu), .break_req(a_bk), .count_clr(a_cl),
    .cpu_en(a_en), .halted(a_hl), .mode(a_md), .step_count(a_cnt)
  );

  step_controller #(.BURST_LEN(16), .CNT_W(4)) dut_b (
    .Clock(clk), .Reset_n(b_rstn), .step_btn(b_st), .run_btn(b_rn),
    .burst_btn(b_bu), .break_req(b_bk), .count_clr(b_cl),
    .cpu_en(b_en), .halted(b_hl), .mode(b_md), .step_count(b_cnt)
  );

  // Input bit codes: reset asserted, step, run, burst, break, clear.
  localparam logic [5:0] N  = 6'd0;
  localparam logic [5:0] RS = 6'd32;
  localparam logic [5:0] ST = 6'd16;
  localparam logic [5:0] RN = 6'd8;
  localparam logic [5:0] BU = 6'd4;
  localparam logic [5:0] BK = 6'd2;
  localparam logic [5:0] CL = 6'd1;

  typedef struct {
    int          dut;
    logic        en;
    logic [1:0]  md;
    logic [31:0] cnt;
    string       nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // One cycle: drive inputs on the falling edge and queue what must appear
  // on the outputs after the following rising edge.
  task automatic cy(input int d, input logic [5:0] in, input logic en,
                    input logic [1:0] md, input logic [31:0] cnt, input string nm);
    exp_t e;
    @(negedge clk);
    a_rstn = 1'b1; a_st = 1'b0; a_rn = 1'b0; a_bu = 1'b0; a_bk = 1'b0; a_cl = 1'b0;
    b_rstn = 1'b1; b_st = 1'b0; b_rn = 1'b0; b_bu = 1'b0; b_bk = 1'b0; b_cl = 1'b0;
    if (d == 0) begin
      a_rstn = ~in[5]; a_st = in[4]; a_rn = in[3]; a_bu = in[2]; a_bk = in[1]; a_cl = in[0];
    end else begin
      b_rstn = ~in[5]; b_st = in[4]; b_rn = in[3]; b_bu = in[2]; b_bk = in[1]; b_cl = in[0];
    end
    e.dut = d; e.en = en; e.md = md; e.cnt = cnt; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: compare registered outputs just after each rising edge.
  exp_t me;
  logic        m_en, m_hl;
  logic [1:0]  m_md;
  logic [31:0] m_cnt;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        me = q.pop_front();
        if (me.dut == 0) begin
          m_en = a_en; m_hl = a_hl; m_md = a_md; m_cnt = a_cnt;
        end else begin
          m_en = b_en; m_hl = b_hl; m_md = b_md; m_cnt = {28'd0, b_cnt};
        end
        checks++;
        if (m_en !== me.en || m_md !== me.md || m_hl !== (me.md == 2'd0) || m_cnt !== me.cnt) begin
          failures++;
          $display("FAIL %s: got cpu_en=%b mode=%0d halted=%b count=%0d, want cpu_en=%b mode=%0d halted=%b count=%0d",
                   me.nm, m_en, m_md, m_hl, m_cnt, me.en, me.md, (me.md == 2'd0), me.cnt);
        end
      end
    end
  end

  initial begin
    // Reset state
    cy(0, RS, 0, 0, 0, "reset0");
    cy(0, RS, 0, 0, 0, "reset1");
    cy(0, N,  0, 0, 0, "idle0");
    cy(0, N,  0, 0, 0, "idle1");

    // Single step: one enabled cycle, then back to HALT
    cy(0, ST, 1, 1, 0, "step_en");
    cy(0, N,  0, 0, 1, "step_done");
    cy(0, N,  0, 0, 1, "step_hold");

    // Burst of 16 with an ignored retrigger mid-way
    cy(0, BU, 1, 3, 1, "burst_start");
    for (int i = 1; i <= 15; i++) cy(0, (i == 5) ? BU : N, 1, 3, 32'(1 + i), "burst_body");
    cy(0, N,  0, 0, 17, "burst_end");
    cy(0, N,  0, 0, 17, "burst_hold");

    // Clear in HALT
    cy(0, CL, 0, 0, 0, "clr_halt");

    // Run for 100 enabled cycles, then breakpoint
    cy(0, RN, 1, 2, 0, "run_start");
    for (int i = 1; i <= 100; i++) cy(0, N, 1, 2, 32'(i), "run_body");
    cy(0, BK, 0, 0, 101, "break_halt");
    cy(0, BK, 0, 0, 101, "break_ignored_halt");
    cy(0, RN | BK, 1, 2, 101, "run_resume_brk");
    cy(0, BK, 0, 0, 102, "brk_in_run");

    // Priority and run toggle
    cy(0, RN | BU | ST, 1, 2, 102, "prio_run");
    cy(0, RN, 0, 0, 103, "run_toggle_off");
    cy(0, RN, 1, 2, 103, "held_run1");
    cy(0, RN, 0, 0, 104, "held_run2");

    // Reset mid-burst with remaining=7, then a full burst
    cy(0, BU, 1, 3, 104, "burst2_start");
    for (int k = 1; k <= 9; k++) cy(0, N, 1, 3, 32'(104 + k), "burst2_body");
    cy(0, RS, 0, 0, 0, "rst_mid_burst");
    cy(0, N,  0, 0, 0, "post_rst");
    cy(0, BU, 1, 3, 0, "burst3_start");
    for (int i = 1; i <= 15; i++) cy(0, N, 1, 3, 32'(i), "burst3_body");
    cy(0, N,  0, 0, 16, "burst3_end");

    // STEP ignores inputs
    cy(0, ST, 1, 1, 16, "step2_en");
    cy(0, RN, 0, 0, 17, "step_ignores_run");

    // Clear coincident with an enabled RUN cycle
    cy(0, RN, 1, 2, 17, "run2_start");
    cy(0, CL, 1, 2, 0, "clr_vs_inc");
    cy(0, RN, 0, 0, 1, "run2_off");

    // Burst aborts by run_btn and by break_req
    cy(0, BU, 1, 3, 1, "burst4_start");
    cy(0, N,  1, 3, 2, "burst4_body");
    cy(0, RN, 0, 0, 3, "burst_abort_run");
    cy(0, ST, 1, 1, 3, "after_abort_step");
    cy(0, N,  0, 0, 4, "after_abort_halt");
    cy(0, BU, 1, 3, 4, "burst5_start");
    cy(0, BK, 0, 0, 5, "burst_abort_brk");

    // 4-bit counter wrap on instance B
    cy(1, RS, 0, 0, 0, "b_reset");
    for (int k = 1; k <= 15; k++) begin
      cy(1, ST, 1, 1, 32'(k - 1), "b_step_en");
      cy(1, N,  0, 0, 32'(k), "b_step_done");
    end
    cy(1, ST, 1, 1, 15, "b_pre_wrap");
    cy(1, N,  0, 0, 0, "b_wrap");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
